// File: rtl/ht_request_arbiter.sv
// Round-robin front end that shares one hash_table pipeline between NUM_PORTS requesters.
// Optional per-port grant counters are built when HT_ARB_STATS_EN is defined.
module ht_request_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int KEY_WIDTH       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid_i,
    output logic [NUM_PORTS-1:0]            req_ready_o,
    input  logic [NUM_PORTS*KEY_WIDTH-1:0]  req_key_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_PORTS*2-1:0]          req_op_i,
    output logic [NUM_PORTS-1:0]            resp_valid_o,
    input  logic [NUM_PORTS-1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0]           resp_data_o,
    output logic [3:0]                      resp_flags_o,
    output logic [KEY_WIDTH-1:0]            ht_key_o,
    output logic [DATA_WIDTH-1:0]           ht_data_o,
    output logic [1:0]                      ht_op_o,
    output logic                            ht_valid_o,
    output logic                            ht_ready_o,
    input  logic                            ht_valid_i,
    input  logic [DATA_WIDTH-1:0]           ht_read_data_i,
    input  logic [3:0]                      ht_flags_i,
    output logic                            err_unexpected_o
`ifdef HT_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         grant_count_o
`endif
);

    localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W:0]    NP      = (ID_W+1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  resp_full_q, resp_full_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [3:0]            resp_flags_q, resp_flags_d;
    logic                  err_q, err_d;
    logic [ID_W-1:0]       tag_mem_q [MAX_OUTSTANDING];

    logic                  found, grant, push, pop, hit, capture, issue_ok;
    logic [ID_W-1:0]       winner, head;
    logic [ID_W:0]         idx_sum, nxt_sum;
    logic [KEY_WIDTH-1:0]  win_key;
    logic [DATA_WIDTH-1:0] win_data;
    logic [1:0]            win_op;
    logic [CNT_W-1:0]      pending;

    // Round-robin search upward from rr_ptr, wrapping at NUM_PORTS-1.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (idx_sum >= NP) idx_sum = idx_sum - NP;
            if (!found && req_valid_i[idx_sum[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_key  = '0;
        win_data = '0;
        win_op   = 2'b00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (winner == ID_W'(p)) begin
                win_key  = req_key_i[p*KEY_WIDTH +: KEY_WIDTH];
                win_data = req_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                win_op   = req_op_i[p*2 +: 2];
            end
        end
    end

    always_comb begin
        head       = tag_mem_q[rd_ptr_q];
        ht_ready_o = ~resp_full_q | resp_ready_i[head];
        issue_ok   = ht_ready_o & (outstanding_q < MAX_CNT) & ~reset;
        grant      = issue_ok & found;
        push       = grant & (win_op != 2'b00);
        pop        = resp_full_q & resp_ready_i[head];
        // Results still owed by the table exclude the one already parked in the register.
        pending    = outstanding_q - CNT_W'(resp_full_q);
        hit        = ht_valid_i & ht_ready_o;
        capture    = hit & (pending != '0);

        ht_valid_o   = push;
        ht_key_o     = grant ? win_key  : '0;
        ht_data_o    = grant ? win_data : '0;
        ht_op_o      = grant ? win_op   : 2'b00;
        req_ready_o  = '0;
        resp_valid_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_ready_o[p]  = grant & (winner == ID_W'(p));
            resp_valid_o[p] = resp_full_q & (head == ID_W'(p));
        end
        resp_data_o      = resp_full_q ? resp_data_q  : '0;
        resp_flags_o     = resp_full_q ? resp_flags_q : 4'b0000;
        err_unexpected_o = err_q;

        nxt_sum = {1'b0, winner} + (ID_W+1)'(1);
        if (nxt_sum >= NP) nxt_sum = '0;
        rr_ptr_d      = grant ? nxt_sum[ID_W-1:0] : rr_ptr_q;
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        outstanding_d = outstanding_q + CNT_W'(push) - CNT_W'(pop);
        resp_full_d   = capture | (resp_full_q & ~pop);
        resp_data_d   = capture ? ht_read_data_i : resp_data_q;
        resp_flags_d  = capture ? ht_flags_i     : resp_flags_q;
        err_d         = err_q | (hit & (pending == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            resp_full_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            resp_full_q   <= resp_full_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        resp_data_q  <= resp_data_d;
        resp_flags_q <= resp_flags_d;
        if (push) tag_mem_q[wr_ptr_q] <= winner;
    end

`ifdef HT_ARB_STATS_EN
    logic [15:0] gcnt_q [NUM_PORTS];
    logic [15:0] gcnt_d [NUM_PORTS];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        grant_count_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gcnt_d[p] = (push && winner == ID_W'(p)) ? sat_inc16(gcnt_q[p]) : gcnt_q[p];
            grant_count_o[p*16 +: 16] = gcnt_q[p];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            gcnt_q[p] <= reset ? 16'd0 : gcnt_d[p];
        end
    end
`endif

endmodule
